// File: rtl/processor_result_display_if.sv
// processor_result_display_if: result/handshake bus between the GCD processor and its display stage
interface processor_result_display_if;
   logic        Halt;
   logic [7:0]  Moutput;
   logic [3:0]  DisplayState;
   logic        busy;
   logic        valid;
   logic [11:0] bcd;
   logic [3:0]  an;
   logic [6:0]  seg;
   modport master (output Halt, Moutput, DisplayState, input busy, valid, bcd, an, seg);
   modport slave (input Halt, Moutput, DisplayState, output busy, valid, bcd, an, seg);
endinterface

// File: rtl/processor_result_display.sv
// processor_result_display: captures the result on Halt rise, converts to BCD, scans a 4-digit seven-segment display
module processor_result_display #(
   parameter int SCAN_DIV = 4
) (
   input logic clock,
   input logic reset,
   processor_result_display_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   state_t state, state_n;
   logic [19:0] sh, sh_n, adj;
   logic [2:0] cnt, cnt_n;
   logic busy, busy_n, valid, valid_n, halt_q, trig;
   logic [11:0] bcd, bcd_n;
   logic [DW-1:0] div;
   logic [1:0] idx;
   logic wrap;
   logic [3:0] an;
   logic [6:0] seg, dig_seg;
   assign trig = bus.Halt & ~halt_q;
   // double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
   assign adj = {sh[19:16] >= 4'd5 ? sh[19:16] + 4'd3 : sh[19:16],
                 sh[15:12] >= 4'd5 ? sh[15:12] + 4'd3 : sh[15:12],
                 sh[11:8] >= 4'd5 ? sh[11:8] + 4'd3 : sh[11:8],
                 sh[7:0]};
   always_comb begin
      state_n = state;
      sh_n = sh;
      cnt_n = cnt;
      busy_n = busy;
      valid_n = valid;
      bcd_n = bcd;
      case (state)
         IDLE: if (trig) begin
            state_n = CONV;
            sh_n = {12'b0, bus.Moutput};
            cnt_n = '0;
            valid_n = 1'b0;
            busy_n = 1'b1;
         end
         CONV: begin
            sh_n = adj << 1;
            cnt_n = cnt + 3'd1;
            state_n = cnt == 3'd7 ? DONE : CONV;
         end
         DONE: begin
            bcd_n = sh[19:8];
            valid_n = 1'b1;
            busy_n = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock)
      if (reset) begin
         state <= IDLE;
         sh <= '0;
         cnt <= '0;
         busy <= 1'b0;
         valid <= 1'b0;
         bcd <= '0;
         halt_q <= 1'b0;
      end else begin
         state <= state_n;
         sh <= sh_n;
         cnt <= cnt_n;
         busy <= busy_n;
         valid <= valid_n;
         bcd <= bcd_n;
         halt_q <= bus.Halt;
      end
   // leading-zero blanking on hundreds and tens; ones always lit
   assign dig_seg = idx == 2'd3 ? SEG[bus.DisplayState] :
                    idx == 2'd2 ? (bcd[11:8] == 4'd0 ? 7'h7F : SEG[bcd[11:8]]) :
                    idx == 2'd1 ? (bcd[11:4] == 8'd0 ? 7'h7F : SEG[bcd[7:4]]) :
                    SEG[bcd[3:0]];
   assign wrap = div == DW'(SCAN_DIV - 1);
   always_ff @(posedge clock)
      if (reset) begin
         div <= '0;
         idx <= '0;
         an <= 4'hF;
         seg <= 7'h7F;
      end else begin
         div <= wrap ? '0 : div + DW'(1);
         idx <= wrap ? idx + 2'd1 : idx;
         an <= ~(4'b1 << idx);
         seg <= dig_seg;
      end
   assign bus.busy = busy;
   assign bus.valid = valid;
   assign bus.bcd = bcd;
   assign bus.an = an;
   assign bus.seg = seg;
endmodule
